// File: rtl/greycode_unary_stream_gen.sv
// greycode_unary_stream_gen: turns each accepted value into a 2^WIDTH-bit unary frame paced by an upstream Gray counter
module greycode_unary_stream_gen #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_value,
  input  logic [WIDTH-1:0] grey_count,
  output logic             grey_enable,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic             out_last,
  output logic             busy,
  output logic             sync_err
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_next;
  logic [WIDTH-1:0] value, shadow, bin;
  logic adv, last_code, accept;
  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
  always_comb begin
    bin = '0;
    for (int i = 0; i < WIDTH; i++) bin[i] = ^(grey_count >> i);
  end
  assign last_code   = &bin;
  assign in_ready    = (state == IDLE) && (grey_count == '0);
  assign accept      = in_valid && in_ready;
  assign adv         = (state == RUN) && (!out_valid || out_ready);
  assign grey_enable = adv;
  assign busy        = (state == RUN);
  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_next;
  end
  // Next state: leave RUN on the load of the final code, the counter wraps to 0 on the same edge
  always_comb begin
    state_next = state;
    state_next = (state == IDLE) ? (accept ? RUN : IDLE) : ((adv && last_code) ? IDLE : RUN);
  end
  // Value capture, output register and shadow count that cross-checks the upstream counter
  always_ff @(posedge clk) begin
    if (rst) begin
      value     <= '0;
      shadow    <= '0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_last  <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      if (accept) begin
        value  <= in_value;
        shadow <= '0;
      end
      if (adv) begin
        out_bit  <= bin < value;
        out_last <= last_code;
        shadow   <= shadow + WIDTH'(1);
        if (bin != shadow) sync_err <= 1'b1;
      end
      out_valid <= adv || (out_valid && !out_ready);
    end
  end
endmodule

// File: tb/tb_greycode_unary_stream_gen.sv
// tb_greycode_unary_stream_gen: scoreboard bench with a modelled upstream Gray counter
module tb_greycode_unary_stream_gen;
  localparam int W = 4;
  localparam int N = 1 << W;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, grey_enable, out_valid, out_ready = 1, out_bit, out_last, busy, sync_err;
  logic [W-1:0] in_value = '0, grey_count, cnt, ovr_val = '0;
  logic skip = 0, ovr = 0, sb_on = 1, stall = 0;
  logic [1:0] held, e;
  logic [1:0] q[$];
  int vq[$];
  int checks = 0, errors = 0, ones = 0, nbits = 0, cyc = 0, last_cyc = -1, acc_cyc = -1;

  greycode_unary_stream_gen #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
    .grey_count(grey_count), .grey_enable(grey_enable), .out_valid(out_valid), .out_ready(out_ready),
    .out_bit(out_bit), .out_last(out_last), .busy(busy), .sync_err(sync_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // upstream Gray counter model, optionally skipping one code
  always @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (grey_enable) cnt <= cnt + (skip ? W'(2) : W'(1));
  end
  assign grey_count = ovr ? ovr_val : (cnt ^ (cnt >> 1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // monitor and scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      ones = 0;
      stall = 0;
    end else begin
      if (stall) chk("hold", {30'd0, out_last, out_bit}, {30'd0, held});
      if (out_valid && !out_ready) chk("gen_low", grey_enable, 0);
      if (out_valid && out_last && !stall) begin
        last_cyc = cyc;
        chk("busy_last", busy, 0);
        if (!ovr) chk("wrap", grey_count, 0);
      end
      if (in_valid && in_ready) begin
        acc_cyc = cyc;
        if (sb_on) begin
          for (int b = 0; b < N; b++) q.push_back({b == N - 1, b < int'(in_value)});
          vq.push_back(int'(in_value));
        end
      end
      if (out_valid && out_ready && sb_on) begin
        if (q.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = q.pop_front();
          chk("bit", {30'd0, out_last, out_bit}, {30'd0, e});
          ones += int'(out_bit);
          nbits++;
          if (out_last) begin
            chk("ones", ones, vq.pop_front());
            ones = 0;
          end
        end
      end
      stall = out_valid && !out_ready;
      held = {out_last, out_bit};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] v);
    in_valid = 1;
    in_value = v;
    for (int i = 0; i < 100 && !in_ready; i++) tick();
    if (!in_ready) chk("accept_timeout", 1, 0);
    tick();
    in_valid = 0;
  endtask

  task automatic wait_done(input bit rnd);
    for (int i = 0; i < 400 && (busy || out_valid); i++) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    out_ready = 1;
    tick();
    tick();
    chk("done_timeout", {30'd0, busy, out_valid}, 0);
  endtask

  task automatic do_reset();
    rst = 1;
    q.delete();
    vq.delete();
    tick();
    rst = 0;
  endtask

  initial begin
    tick();
    do_reset();
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", sync_err, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_gen", grey_enable, 0);
    // single frame, latency
    in_valid = 1;
    in_value = 5;
    tick();
    in_valid = 0;
    chk("t1_busy", busy, 1);
    chk("t1_nolat", out_valid, 0);
    tick();
    chk("t1_first", out_valid, 1);
    wait_done(0);
    chk("t1_err", sync_err, 0);
    // boundary values
    send(0);
    wait_done(0);
    send(15);
    wait_done(0);
    chk("t2_cnt0", grey_count, 0);
    // random backpressure
    send(9);
    wait_done(1);
    // back-to-back
    in_valid = 1;
    in_value = 3;
    for (int i = 0; i < 10 && !in_ready; i++) tick();
    tick();
    in_value = 12;
    for (int i = 0; i < 100 && !in_ready; i++) tick();
    chk("t4_ready", in_ready, 1);
    tick();
    in_valid = 0;
    chk("t4_gap", acc_cyc, last_cyc);
    wait_done(0);
    chk("sb_empty", q.size(), 0);
    // sync fault
    sb_on = 0;
    send(8);
    tick();
    tick();
    skip = 1;
    tick();
    skip = 0;
    chk("t5_pre", sync_err, 0);
    tick();
    chk("t5_set", sync_err, 1);
    wait_done(0);
    chk("t5_sticky", sync_err, 1);
    ovr = 1;
    ovr_val = 3;
    #1;
    chk("t5_block", in_ready, 0);
    in_valid = 1;
    in_value = 4;
    tick();
    tick();
    chk("t5_nostart", busy, 0);
    in_valid = 0;
    ovr = 0;
    chk("t5_sticky2", sync_err, 1);
    do_reset();
    chk("t5_clr", sync_err, 0);
    sb_on = 1;
    // reset mid-frame
    nbits = 0;
    send(10);
    for (int i = 0; i < 100 && nbits < 6; i++) tick();
    rst = 1;
    q.delete();
    vq.delete();
    tick();
    rst = 0;
    chk("t6_valid", out_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_err", sync_err, 0);
    send(2);
    wait_done(0);
    chk("t6_empty", q.size(), 0);
    chk("t6_vq", vq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/greycode_unary_stream_gen.md
Name: greycode_unary_stream_gen

Overview:
- Consumes the registered Gray-code count of the upstream `greycode_counter` and drives that counter's enable.
- Converts each accepted binary value into a unary bitstream of exactly 2^WIDTH bits, with one bit per counter step.
- The number of 1s in the frame equals the value.
- It is the first stage of the unary compression datapath: upstream is the Gray counter plus the value source, downstream is any valid/ready bitstream consumer.

Parameters:
- WIDTH, 8, bit width of the value and of the Gray count; frame length is 2^WIDTH.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  value offered
- in_ready  out  1  block can accept a value
- in_value  in  WIDTH  binary value to encode, range 0..2^WIDTH-1
- grey_count  in  WIDTH  current registered Gray count from upstream counter
- grey_enable  out  1  advance request to upstream counter (combinational)
- out_valid  out  1  out_bit valid
- out_ready  in  1  downstream accepts out_bit
- out_bit  out  1  unary stream bit
- out_last  out  1  marks final bit (index 2^WIDTH-1) of a frame
- busy  out  1  frame in progress (state RUN)
- sync_err  out  1  sticky: Gray count disagreed with internal shadow count

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE.
  - Value register and shadow counter go to 0.
  - out_valid, out_bit, out_last and sync_err go to 0.
  - Reset mid-frame aborts the frame; no further bits are emitted.
  - The upstream counter has its own reset; both must be reset together.
- States:
  - IDLE:
    - in_ready = (grey_count == 0).
    - On in_valid & in_ready: latch in_value, clear shadow to 0, go to RUN.
    - grey_enable = 0.
  - RUN:
    - in_ready = 0.
    - adv = !out_valid | out_ready, and grey_enable = adv.
    - On adv:
      - Load the output register: out_bit = (B < value), where B is grey_count decoded to binary (B[W-1]=G[W-1], B[i]=B[i+1]^G[i]).
      - out_last = (B == 2^WIDTH-1).
      - Increment shadow, which wraps at WIDTH bits.
    - If adv and B == 2^WIDTH-1, go to IDLE. The counter wraps to Gray 0 on that same edge, so the next frame can start at once.
- Output register:
  - out_valid is set on each adv load.
  - out_valid is cleared when out_valid & out_ready and no new load happens that cycle.
  - A simultaneous drain and load keeps out_valid=1 with the new data.
  - out_bit and out_last are held stable while out_valid & !out_ready.
- Backpressure: when out_ready=0 with out_valid=1, grey_enable=0 and the count holds, so no bit is lost or duplicated.
- Latency and throughput:
  - Value accepted at edge t, RUN from t.
  - First out_valid is visible after edge t+1.
  - With out_ready held at 1, a frame is 2^WIDTH back-to-back bits.
  - The next frame's first bit can follow with a single-cycle gap (the IDLE accept cycle).
- Comparison: value 0 gives all zeros. Value 2^WIDTH-1 gives ones everywhere except the final bit. The ones count always equals value.
- sync_err:
  - Set on any RUN adv cycle where B != shadow.
  - Stays set until rst; it does not stop operation.
- busy = (state == RUN).
- in_valid while busy is ignored; the value is not captured.

Test Plan:
1. WIDTH=4, reset, in_value=5, out_ready=1 → after 1 cycle, 16 consecutive out_valid bits, pattern 1111100000000000, out_last only on the 16th, sync_err=0, busy falls after the last load.
2. Boundary values: in_value=0 gives 16 zeros; in_value=15 gives 15 ones then a 0 with out_last; upstream count returns to 0 after each frame.
3. Backpressure on in_value=9: toggle out_ready pseudo-randomly → same 9 ones and 7 zeros in order, grey_enable low whenever out_valid & !out_ready, out_bit stable while stalled.
4. Back-to-back: in_valid held with values 3 then 12 → second frame accepted the cycle after the first out_last load; streams of 3 and 12 ones, no bit lost or duplicated.
5. Sync fault: force grey_count to skip one code mid-frame → sync_err rises on that cycle and remains 1 until rst; start blocked (in_ready=0) while grey_count≠0 in IDLE.
6. Reset mid-frame: assert rst after 6 bits of value 10 → next cycle out_valid=0, busy=0, sync_err=0; a new frame with value 2 after reset emits exactly 2 ones.
